ptp_xgmii_rx_monitor: RTL and testbench
=======================================

# ptp_xgmii_rx_monitor

- Receive-side monitor for the 64-bit XGMII stream leaving a ptpv2_endpoint (through channel_model).
- Delineates frames on start/terminate control characters, checks preamble/SFD, length and error characters, and extracts EtherType (one optional VLAN tag) and the PTP messageType.
- Emits a one-cycle per-frame report plus running counters, so benches can check every frame an endpoint transmits without decoding XGMII by hand.
- FCS is not checked.

## Interface

Parameters:
- MIN_LEN, 64: minimum legal frame length in bytes (DA through FCS).
- MAX_LEN, 1522: maximum legal frame length in bytes.
- PTP_ETYPE, 16'h88F7: EtherType identifying PTP over L2.

Ports:
- rx_clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- xge_rxd_i  in  64  XGMII data; lane n = bits [8n+7:8n], lane 0 first on the wire.
- xge_rxc_i  in  8  XGMII control; bit n=1 marks lane n as a control character.
- frame_valid_o  out  1  one-cycle pulse: report fields valid.
- frame_len_o  out  16  data bytes DA..FCS, saturating at 16'hFFFF.
- eth_type_o  out  16  EtherType, the inner one when a 0x8100 tag is present.
- is_ptp_o  out  1  eth_type_o == PTP_ETYPE.
- ptp_msg_type_o  out  4  low nibble of first payload byte; 0 when !is_ptp_o.
- err_o  out  4  [0] bad preamble/SFD, [1] /E/ (0xFE) inside frame, [2] length < MIN_LEN or > MAX_LEN, [3] frame truncated by new /S/.
- frame_cnt_o  out  32  reported frames, wraps.
- err_cnt_o  out  16  reported frames with err_o != 0, saturates at 16'hFFFF.

## Operation

- Start /S/ = 0xFB with rxc=1, legal only in lane 0 or lane 4. Terminate /T/ = 0xFD with rxc=1.
- Lane-0 start: lanes 1..6 must be 0x55 and lane 7 0xD5, all with rxc=0. The next word carries frame bytes 0..7.
- Lane-4 start: lanes 5..7 = 0x55 in this word. The next word's lanes 0..2 = 0x55 and lane 3 = 0xD5, and its lanes 4..7 are frame bytes 0..3.
- Any preamble/SFD mismatch sets err[0]. The frame is still tracked.
- States:
  - IDLE: wait for /S/. Lane-0 /S/ -> DATA. Lane-4 /S/ -> PRE.
  - PRE: one word (SFD word) -> DATA.
  - DATA: accumulate bytes.
    - /T/ in lane k: lanes 0..k-1 are data; report; -> IDLE.
    - /T/ in lane 0 contributes zero bytes.
- Control characters in DATA other than /T/ or /S/: 0xFE sets err[1]. Any other value also sets err[1] and counts as 1 byte.
- /S/ in DATA: report the current frame with err[3] set. The /S/ then begins a new frame (-> DATA or PRE) in the same cycle.
- Byte offsets are counted from DA byte 0:
  - EtherType = bytes 12..13.
  - If EtherType = 0x8100, EtherType = bytes 16..17 and payload starts at 18; otherwise payload starts at 14.
  - A field not reached before /T/ reports as 0.
- err[2] is evaluated on the final, unsaturated-compare length (saturated value compared).
- frame_cnt_o increments on every frame_valid_o. err_cnt_o increments when the reported err_o != 0.

## Timing

- Reset: state IDLE. All outputs 0: frame_valid_o, frame_len_o, eth_type_o, is_ptp_o, ptp_msg_type_o, err_o, frame_cnt_o, err_cnt_o.
- rst asserted mid-frame discards the frame with no report. Counters clear.
- Latency: frame_valid_o is high exactly one cycle, in the cycle after the word containing /T/ (or truncating /S/) is sampled.
- Report fields and counters update in the same cycle as frame_valid_o. They hold until the next report.
- Back-to-back: /T/ and /S/ in the same word (/T/ lane ≤ 3, /S/ lane 4) closes the old frame and opens the new one. No frame is lost.
- Throughput: a 64-byte frame every 10 words must be reported without loss.

## Test plan

- Lane-0 start, 64-byte frame, EtherType 0x88F7, payload byte 0 = 0x01, /T/ in lane 0 of word 9 -> one pulse, frame_len_o=64, is_ptp_o=1, ptp_msg_type_o=1, err_o=0, frame_cnt_o=1.
- Lane-4 start, VLAN tag 0x8100 then 0x88F7, payload byte 0 = 0x09, 68 bytes -> frame_len_o=68, eth_type_o=16'h88F7, ptp_msg_type_o=9, err_o=0.
- 60-byte frame with EtherType 0x0800, SFD replaced by 0xD4 -> frame_len_o=60, is_ptp_o=0, ptp_msg_type_o=0, err_o=4'b0101, err_cnt_o=1.
- /E/ in lane 3 of word 4, 100-byte frame -> err_o[1]=1, frame_len_o=100.
- /S/ arriving at DA byte 40 of a frame, followed by a good 64-byte frame -> two pulses: first frame_len_o=40 with err_o=4'b1100, second err_o=0; frame_cnt_o=2.
- rst pulsed at byte 30 of a frame, then a good 64-byte frame -> no report for the first frame, one report for the second, frame_cnt_o=1.

Source files
------------

// File: rtl/ptp_xgmii_rx_monitor.sv
// ptp_xgmii_rx_monitor
// Receive-side monitor for a 64-bit XGMII stream. It finds frames using the
// start and terminate control characters, checks the preamble/SFD, the frame
// length and any error characters, and extracts the EtherType (skipping one
// optional 0x8100 tag) and the PTP messageType. For every frame it emits a
// one-cycle report and updates running counters. FCS is not checked.
//
// States:
//   IDLE | between frames, waiting for /S/ in lane 0 or lane 4
//   PRE  | lane-4 start seen; this word holds the rest of the preamble and SFD
//        | in lanes 0..3 and frame bytes 0..3 in lanes 4..7
//   DATA | inside a frame, collecting frame bytes
//
// Ports:
//   rx_clk          clock; all logic runs on its rising edge
//   rst             synchronous active-high reset
//   xge_rxd_i[63:0] XGMII data; lane n is bits [8n+7:8n], lane 0 is first on the wire
//   xge_rxc_i[7:0]  XGMII control; bit n set means lane n is a control character
//   frame_valid_o   one-cycle pulse when the report fields below are valid
//   frame_len_o     frame bytes from DA through FCS, saturating at 16'hFFFF
//   eth_type_o      EtherType; the inner one when a VLAN tag is present
//   is_ptp_o        eth_type_o equals PTP_ETYPE
//   ptp_msg_type_o  low nibble of the first payload byte; 0 when not PTP
//   err_o           [0] bad preamble/SFD, [1] control char inside frame,
//                   [2] length out of range, [3] frame truncated by new /S/
//   frame_cnt_o     number of reported frames; wraps
//   err_cnt_o       number of reported frames with errors; saturates
module ptp_xgmii_rx_monitor #(
  parameter int unsigned MIN_LEN   = 64,
  parameter int unsigned MAX_LEN   = 1522,
  parameter logic [15:0] PTP_ETYPE = 16'h88F7
) (
  input  logic        rx_clk,
  input  logic        rst,
  input  logic [63:0] xge_rxd_i,
  input  logic [7:0]  xge_rxc_i,
  output logic        frame_valid_o,
  output logic [15:0] frame_len_o,
  output logic [15:0] eth_type_o,
  output logic        is_ptp_o,
  output logic [3:0]  ptp_msg_type_o,
  output logic [3:0]  err_o,
  output logic [31:0] frame_cnt_o,
  output logic [15:0] err_cnt_o
);

  localparam logic [7:0] C_START = 8'hFB;
  localparam logic [7:0] C_TERM  = 8'hFD;
  localparam logic [7:0] C_ERR   = 8'hFE;
  localparam logic [7:0] C_PRE   = 8'h55;
  localparam logic [7:0] C_SFD   = 8'hD5;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA} state_t;

  state_t         state_q, state_d;
  logic [15:0]    len_q, len_d;
  // Captured header bytes at offsets 12, 13, 14, 16, 17 and 18. They are
  // cleared at frame start, so any field the frame never reaches reports 0.
  logic [5:0][7:0] fld_q, fld_d;
  logic           pre_err_q, pre_err_d;
  logic           ctl_err_q, ctl_err_d;

  logic           valid_q;
  logic [15:0]    flen_q, etype_q, ecnt_q;
  logic           ptp_q;
  logic [3:0]     msg_q, err_q;
  logic [31:0]    fcnt_q;

  logic           lane0_s, lane4_s, pre0_ok, pre4_ok, sfd_ok;
  logic [16:0]    off;
  logic           stop, found_t, found_s, rep;
  logic [2:0]     end_lane;
  logic [7:0]     lane_b;
  logic           start0, start4;
  logic [15:0]    outer_et;
  logic [15:0]    rep_len, rep_et;
  logic [7:0]     rep_pay;
  logic           rep_ptp;
  logic [3:0]     rep_msg, rep_err;

  assign lane0_s = xge_rxc_i[0] && (xge_rxd_i[7:0] == C_START);
  assign lane4_s = xge_rxc_i[4] && (xge_rxd_i[39:32] == C_START);
  assign pre0_ok = (xge_rxd_i[63:8] == {C_SFD, {6{C_PRE}}}) && (xge_rxc_i[7:1] == 7'd0);
  assign pre4_ok = (xge_rxd_i[63:40] == {3{C_PRE}}) && (xge_rxc_i[7:5] == 3'd0);
  assign sfd_ok  = (xge_rxd_i[31:0] == {C_SFD, {3{C_PRE}}}) && (xge_rxc_i[3:0] == 4'd0);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    fld_d     = fld_q;
    pre_err_d = pre_err_q;
    ctl_err_d = ctl_err_q;
    off       = {1'b0, len_q};
    stop      = 1'b0;
    found_t   = 1'b0;
    found_s   = 1'b0;
    end_lane  = 3'd0;
    lane_b    = 8'd0;
    start0    = 1'b0;
    start4    = 1'b0;

    if (state_q != S_IDLE) begin
      if (state_q == S_PRE && !sfd_ok) pre_err_d = 1'b1;
      // Walk the lanes in wire order until the first /T/ or /S/. In PRE only
      // lanes 4..7 carry frame bytes.
      for (int i = 0; i < 8; i++) begin
        lane_b = xge_rxd_i[8*i +: 8];
        if (!stop && (state_q == S_DATA || i >= 4)) begin
          if (xge_rxc_i[i] && (lane_b == C_TERM || lane_b == C_START)) begin
            stop     = 1'b1;
            found_t  = (lane_b == C_TERM);
            found_s  = (lane_b == C_START);
            end_lane = 3'(i);
          end else begin
            if (xge_rxc_i[i]) ctl_err_d = 1'b1;
            // /E/ only flags the error; any other stray control char still
            // occupies a byte position.
            if (!xge_rxc_i[i] || lane_b != C_ERR) begin
              case (off)
                17'd12:  fld_d[0] = lane_b;
                17'd13:  fld_d[1] = lane_b;
                17'd14:  fld_d[2] = lane_b;
                17'd16:  fld_d[3] = lane_b;
                17'd17:  fld_d[4] = lane_b;
                17'd18:  fld_d[5] = lane_b;
                default: ;
              endcase
              off = off + 17'd1;
            end
          end
        end
      end
    end

    len_d    = off[16] ? 16'hFFFF : off[15:0];
    rep      = found_t | found_s;
    outer_et = {fld_d[0], fld_d[1]};
    rep_len  = len_d;
    rep_et   = (outer_et == 16'h8100) ? {fld_d[3], fld_d[4]} : outer_et;
    rep_pay  = (outer_et == 16'h8100) ? fld_d[5] : fld_d[2];
    rep_ptp  = (rep_et == PTP_ETYPE);
    rep_msg  = rep_ptp ? rep_pay[3:0] : 4'd0;
    rep_err  = {found_s,
                (32'(rep_len) < MIN_LEN) || (32'(rep_len) > MAX_LEN),
                ctl_err_d,
                pre_err_d};

    if (state_q == S_IDLE) begin
      start0 = lane0_s;
      start4 = !lane0_s && lane4_s;
    end else if (found_s) begin
      start0 = (end_lane == 3'd0);
      start4 = (end_lane == 3'd4);
    end else if (found_t) begin
      // /T/ in the low half may share its word with a lane-4 /S/.
      start4 = (end_lane < 3'd4) && lane4_s;
    end

    if (start0 || start4) begin
      state_d   = start0 ? S_DATA : S_PRE;
      len_d     = 16'd0;
      fld_d     = '0;
      ctl_err_d = 1'b0;
      pre_err_d = start0 ? !pre0_ok : !pre4_ok;
    end else if (rep) begin
      state_d = S_IDLE;
    end else if (state_q == S_PRE) begin
      state_d = S_DATA;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= 16'd0;
      fld_q     <= '0;
      pre_err_q <= 1'b0;
      ctl_err_q <= 1'b0;
      valid_q   <= 1'b0;
      flen_q    <= 16'd0;
      etype_q   <= 16'd0;
      ptp_q     <= 1'b0;
      msg_q     <= 4'd0;
      err_q     <= 4'd0;
      fcnt_q    <= 32'd0;
      ecnt_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      fld_q     <= fld_d;
      pre_err_q <= pre_err_d;
      ctl_err_q <= ctl_err_d;
      valid_q   <= rep;
      if (rep) begin
        flen_q  <= rep_len;
        etype_q <= rep_et;
        ptp_q   <= rep_ptp;
        msg_q   <= rep_msg;
        err_q   <= rep_err;
        fcnt_q  <= fcnt_q + 32'd1;
        if (rep_err != 4'd0 && ecnt_q != 16'hFFFF) ecnt_q <= ecnt_q + 16'd1;
      end
    end
  end

  assign frame_valid_o  = valid_q;
  assign frame_len_o    = flen_q;
  assign eth_type_o     = etype_q;
  assign is_ptp_o       = ptp_q;
  assign ptp_msg_type_o = msg_q;
  assign err_o          = err_q;
  assign frame_cnt_o    = fcnt_q;
  assign err_cnt_o      = ecnt_q;

endmodule

// File: tb/tb_ptp_xgmii_rx_monitor.sv
module tb_ptp_xgmii_rx_monitor;

  logic        rx_clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] xge_rxd_i = {8{8'h07}};
  logic [7:0]  xge_rxc_i = 8'hFF;
  logic        frame_valid_o;
  logic [15:0] frame_len_o;
  logic [15:0] eth_type_o;
  logic        is_ptp_o;
  logic [3:0]  ptp_msg_type_o;
  logic [3:0]  err_o;
  logic [31:0] frame_cnt_o;
  logic [15:0] err_cnt_o;

  always #5 rx_clk = ~rx_clk;

  ptp_xgmii_rx_monitor dut (
    .rx_clk         (rx_clk),
    .rst            (rst),
    .xge_rxd_i      (xge_rxd_i),
    .xge_rxc_i      (xge_rxc_i),
    .frame_valid_o  (frame_valid_o),
    .frame_len_o    (frame_len_o),
    .eth_type_o     (eth_type_o),
    .is_ptp_o       (is_ptp_o),
    .ptp_msg_type_o (ptp_msg_type_o),
    .err_o          (err_o),
    .frame_cnt_o    (frame_cnt_o),
    .err_cnt_o      (err_cnt_o)
  );

  typedef struct {
    logic [15:0] len;
    logic [15:0] et;
    logic        ptp;
    logic [3:0]  msg;
    logic [3:0]  err;
    logic [31:0] fcnt;
    logic [15:0] ecnt;
  } rep_t;

  typedef struct {
    int          sl;
    int          n;
    logic [15:0] et;
    logic [15:0] inner;
    logic [7:0]  pay;
    logic [7:0]  sfd;
    int          epos;
    int          elen;
    logic [15:0] eet;
    logic        eptp;
    logic [3:0]  emsg;
    logic [3:0]  eerr;
  } vec_t;

  localparam logic [8:0] IDLE_L = {1'b1, 8'h07};

  rep_t       rep_q[$];
  logic [8:0] lanes[$];
  vec_t       vecs[9];
  int         checks = 0;
  int         errors = 0;
  int         exp_fcnt = 0;
  int         exp_ecnt = 0;

  // Every valid cycle is logged, so a pulse longer than one cycle shows up as
  // an extra report.
  always @(negedge rx_clk) begin
    if (frame_valid_o) begin
      rep_t r;
      r.len  = frame_len_o;
      r.et   = eth_type_o;
      r.ptp  = is_ptp_o;
      r.msg  = ptp_msg_type_o;
      r.err  = err_o;
      r.fcnt = frame_cnt_o;
      r.ecnt = err_cnt_o;
      rep_q.push_back(r);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_word(input logic [63:0] d, input logic [7:0] c);
    xge_rxd_i = d;
    xge_rxc_i = c;
    @(posedge rx_clk);
    #1;
  endtask

  task automatic drive_idle(input int n);
    for (int k = 0; k < n; k++) drive_word({8{8'h07}}, 8'hFF);
  endtask

  task automatic push_start(input int lane, input logic [7:0] sfd);
    while (lanes.size() % 8 != lane) lanes.push_back(IDLE_L);
    lanes.push_back({1'b1, 8'hFB});
    for (int k = 0; k < 6; k++) lanes.push_back({1'b0, 8'h55});
    lanes.push_back({1'b0, sfd});
  endtask

  task automatic push_body(input int n, input logic [15:0] et, input logic [15:0] inner,
                           input logic [7:0] pay, input int epos);
    logic       vlan;
    logic [7:0] b;
    vlan = (et == 16'h8100);
    for (int k = 0; k < n; k++) begin
      if (k == epos) lanes.push_back({1'b1, 8'hFE});
      b = 8'(k);
      if (k < 12)       b = 8'hA0 + 8'(k);
      else if (k == 12) b = et[15:8];
      else if (k == 13) b = et[7:0];
      else if (k == 14) b = vlan ? 8'h00 : pay;
      else if (k == 15 && vlan) b = 8'h05;
      else if (k == 16 && vlan) b = inner[15:8];
      else if (k == 17 && vlan) b = inner[7:0];
      else if (k == 18 && vlan) b = pay;
      lanes.push_back({1'b0, b});
    end
  endtask

  task automatic push_term();
    lanes.push_back({1'b1, 8'hFD});
  endtask

  task automatic flush();
    logic [63:0] d;
    logic [7:0]  c;
    logic [8:0]  l;
    while (lanes.size() % 8 != 0) lanes.push_back(IDLE_L);
    while (lanes.size() != 0) begin
      for (int k = 0; k < 8; k++) begin
        l = lanes.pop_front();
        d[8*k +: 8] = l[7:0];
        c[k] = l[8];
      end
      drive_word(d, c);
    end
  endtask

  task automatic check_rep(input string tag, input int elen, input logic [15:0] eet,
                           input logic eptp, input logic [3:0] emsg, input logic [3:0] eerr);
    rep_t r;
    exp_fcnt++;
    if (eerr != 4'd0) exp_ecnt++;
    if (rep_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_present actual=0 required=1", tag);
      return;
    end
    r = rep_q.pop_front();
    chk({tag, "_len"},  32'(r.len),  32'(elen));
    chk({tag, "_et"},   32'(r.et),   32'(eet));
    chk({tag, "_ptp"},  32'(r.ptp),  32'(eptp));
    chk({tag, "_msg"},  32'(r.msg),  32'(emsg));
    chk({tag, "_err"},  32'(r.err),  32'(eerr));
    chk({tag, "_fcnt"}, r.fcnt,      32'(exp_fcnt));
    chk({tag, "_ecnt"}, 32'(r.ecnt), 32'(exp_ecnt));
  endtask

  initial begin
    //           sl  n     et        inner     pay    sfd    epos len   eet       ptp   msg   err
    vecs[0] = '{0,  64,   16'h88F7, 16'h0000, 8'h01, 8'hD5, -1,  64,   16'h88F7, 1'b1, 4'h1, 4'h0};
    vecs[1] = '{4,  68,   16'h8100, 16'h88F7, 8'h09, 8'hD5, -1,  68,   16'h88F7, 1'b1, 4'h9, 4'h0};
    vecs[2] = '{0,  60,   16'h0800, 16'h0000, 8'h45, 8'hD4, -1,  60,   16'h0800, 1'b0, 4'h0, 4'h5};
    vecs[3] = '{0,  100,  16'h0800, 16'h0000, 8'h45, 8'hD5, 27,  100,  16'h0800, 1'b0, 4'h0, 4'h2};
    vecs[4] = '{4,  63,   16'h88F7, 16'h0000, 8'h0B, 8'hD5, -1,  63,   16'h88F7, 1'b1, 4'hB, 4'h4};
    vecs[5] = '{0,  1522, 16'h88F7, 16'h0000, 8'h53, 8'hD5, -1,  1522, 16'h88F7, 1'b1, 4'h3, 4'h0};
    vecs[6] = '{4,  1523, 16'h0800, 16'h0000, 8'h45, 8'hD5, -1,  1523, 16'h0800, 1'b0, 4'h0, 4'h4};
    vecs[7] = '{4,  64,   16'h8100, 16'h0800, 8'h05, 8'hD5, -1,  64,   16'h0800, 1'b0, 4'h0, 4'h0};
    vecs[8] = '{0,  10,   16'h88F7, 16'h0000, 8'h01, 8'hD5, -1,  10,   16'h0000, 1'b0, 4'h0, 4'h4};

    repeat (3) @(posedge rx_clk);
    #1;
    chk("rst_valid", 32'(frame_valid_o), 32'd0);
    chk("rst_len",   32'(frame_len_o), 32'd0);
    chk("rst_et",    32'(eth_type_o), 32'd0);
    chk("rst_ptp",   32'(is_ptp_o), 32'd0);
    chk("rst_msg",   32'(ptp_msg_type_o), 32'd0);
    chk("rst_err",   32'(err_o), 32'd0);
    chk("rst_fcnt",  frame_cnt_o, 32'd0);
    chk("rst_ecnt",  32'(err_cnt_o), 32'd0);
    rst = 1'b0;
    drive_idle(2);

    for (int v = 0; v < 9; v++) begin
      push_start(vecs[v].sl, vecs[v].sfd);
      push_body(vecs[v].n, vecs[v].et, vecs[v].inner, vecs[v].pay, vecs[v].epos);
      push_term();
      flush();
      drive_idle(3);
      chk($sformatf("vec%0d_count", v), 32'(rep_q.size()), 32'd1);
      check_rep($sformatf("vec%0d", v), vecs[v].elen, vecs[v].eet, vecs[v].eptp,
                vecs[v].emsg, vecs[v].eerr);
    end

    // Frame cut off by a new /S/ at DA byte 40, followed by a good frame.
    push_start(0, 8'hD5);
    push_body(40, 16'h0800, 16'h0000, 8'h45, -1);
    push_start(0, 8'hD5);
    push_body(64, 16'h88F7, 16'h0000, 8'h02, -1);
    push_term();
    flush();
    drive_idle(3);
    chk("trunc_count", 32'(rep_q.size()), 32'd2);
    check_rep("trunc_a", 40, 16'h0800, 1'b0, 4'h0, 4'hC);
    check_rep("trunc_b", 64, 16'h88F7, 1'b1, 4'h2, 4'h0);

    // /T/ in lane 3 and /S/ in lane 4 of the same word.
    push_start(0, 8'hD5);
    push_body(67, 16'h0800, 16'h0000, 8'h45, -1);
    push_term();
    push_start(4, 8'hD5);
    push_body(64, 16'h88F7, 16'h0000, 8'h03, -1);
    push_term();
    flush();
    drive_idle(3);
    chk("b2b_count", 32'(rep_q.size()), 32'd2);
    check_rep("b2b_a", 67, 16'h0800, 1'b0, 4'h0, 4'h0);
    check_rep("b2b_b", 64, 16'h88F7, 1'b1, 4'h3, 4'h0);

    // Three 64-byte frames at one per 10 words.
    for (int f = 0; f < 3; f++) begin
      push_start(0, 8'hD5);
      push_body(64, 16'h88F7, 16'h0000, 8'(f + 4), -1);
      push_term();
    end
    flush();
    drive_idle(3);
    chk("rate_count", 32'(rep_q.size()), 32'd3);
    for (int f = 0; f < 3; f++)
      check_rep($sformatf("rate%0d", f), 64, 16'h88F7, 1'b1, 4'(f + 4), 4'h0);

    // Reset in the middle of a frame discards it and clears the counters.
    push_start(0, 8'hD5);
    push_body(32, 16'h88F7, 16'h0000, 8'h01, -1);
    flush();
    rst = 1'b1;
    drive_idle(1);
    rst = 1'b0;
    chk("mrst_valid", 32'(frame_valid_o), 32'd0);
    chk("mrst_fcnt",  frame_cnt_o, 32'd0);
    chk("mrst_ecnt",  32'(err_cnt_o), 32'd0);
    exp_fcnt = 0;
    exp_ecnt = 0;
    drive_idle(2);
    chk("mrst_none", 32'(rep_q.size()), 32'd0);
    push_start(0, 8'hD5);
    push_body(64, 16'h88F7, 16'h0000, 8'h01, -1);
    push_term();
    flush();
    drive_idle(3);
    chk("mrst_count", 32'(rep_q.size()), 32'd1);
    check_rep("mrst", 64, 16'h88F7, 1'b1, 4'h1, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
